mem_bus_arbiter: RTL

//  Shares the single memory port between two masters: M0 = core load/store/ifetch
//  (mem_addr/mem_wdata/mem_type/mem_sign, request = rimem|rdmem|wmem) and M1 = JTAG debug access.

---
 rtl/mem_bus_arbiter_if.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two memory masters, the arbiter and the single slave port.
// The arbiter takes the 'slave' modport (it answers the masters); the environment takes 'master'.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 2
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [TYPE_W-1:0] m0_type;
  logic              m0_sign;
  logic              m0_busy;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [TYPE_W-1:0] m1_type;
  logic              m1_sign;
  logic              m1_busy;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [TYPE_W-1:0] s_type;
  logic              s_sign;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_type, m0_sign,
    output m0_busy, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_type, m1_sign,
    output m1_busy, m1_rdata, m1_err,
    output s_req, s_we, s_addr, s_wdata, s_type, s_sign,
    input  s_ack, s_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_type, m0_sign,
    input  m0_busy, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_type, m1_sign,
    input  m1_busy, m1_rdata, m1_err,
    input  s_req, s_we, s_addr, s_wdata, s_type, s_sign,
    output s_ack, s_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between the core (M0) and JTAG debug (M1).
// The granted command is held on the slave bus for the whole transaction; an optional timeout frees a dead slave.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TYPE_W  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TYPE_W-1:0] size;
    logic              sign;
  } cmd_t;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rrPtr_q, rrPtr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  cmd_t              cmd_q, cmd_d;

  cmd_t cmd0, cmd1;
  logic grantee;
  logic timeoutHit;
  logic done;
  logic timeoutErr;

  assign cmd0 = {bus.m0_we, bus.m0_addr, bus.m0_wdata, bus.m0_type, bus.m0_sign};
  assign cmd1 = {bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_type, bus.m1_sign};

  // Ties go to the round-robin pointer; a lone requester always wins.
  assign grantee    = (bus.m0_req && bus.m1_req) ? rrPtr_q : bus.m1_req;
  assign timeoutHit = (TIMEOUT != 0) && (tcnt_q == TCNT_W'(TIMEOUT - 1));
  assign done       = (state_q == BUSY) && (bus.s_ack || timeoutHit);
  assign timeoutErr = (state_q == BUSY) && timeoutHit && !bus.s_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rrPtr_q <= 1'b0;
      tcnt_q  <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rrPtr_q <= rrPtr_d;
      tcnt_q  <= tcnt_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rrPtr_d = rrPtr_q;
    tcnt_d  = tcnt_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          owner_d = grantee;
          cmd_d   = grantee ? cmd1 : cmd0;
          tcnt_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The pointer moves even if the owner dropped its request mid-access.
        if (done) begin
          state_d = IDLE;
          rrPtr_d = ~owner_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_req   = (state_q == BUSY);
  assign bus.s_we    = cmd_q.we;
  assign bus.s_addr  = cmd_q.addr;
  assign bus.s_wdata = cmd_q.wdata;
  assign bus.s_type  = cmd_q.size;
  assign bus.s_sign  = cmd_q.sign;

  assign bus.m0_busy  = bus.m0_req & ~(done & ~owner_q);
  assign bus.m1_busy  = bus.m1_req & ~(done & owner_q);
  assign bus.m0_rdata = (~owner_q & bus.s_ack) ? bus.s_rdata : '0;
  assign bus.m1_rdata = (owner_q & bus.s_ack) ? bus.s_rdata : '0;
  assign bus.m0_err   = timeoutErr & ~owner_q;
  assign bus.m1_err   = timeoutErr & owner_q;

endmodule
